// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int MaskWidth = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_e;

    typedef enum logic {
        GRANT_INSTR,
        GRANT_DATA
    } arb_grant_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_watchdog.sv
// Watchdog for one memory access.
// The count is cleared on every grant and advances once per BUSY cycle.
// 'expired' rises during the BUSY cycle in which the count reaches TimeoutCycles.
module mem_arb_watchdog #(
    parameter int TimeoutCycles = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CountWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(TimeoutCycles - 1);
    localparam logic [CountWidth-1:0] MaxCount  = CountWidth'(TimeoutCycles);

    logic [CountWidth-1:0] r_count;

    // Count BUSY cycles since the grant. Saturate so the count cannot wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != MaxCount)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The current BUSY cycle is the last one permitted for this access.
    assign expired = enable && (r_count == LastCount);

endmodule : mem_arb_watchdog

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data requesters onto one shared memory port.
// The sequence is IDLE (grant) -> BUSY (wait for mem_valid or the watchdog) -> RESP (one-cycle valid).
// Optional feature: define ARB_ROUND_ROBIN_EN to resolve conflicts round-robin using a last-grant flop.
// Without it, data always wins a conflict.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 instr_request,
    input  logic [DataWidth-1:0] instr_address,
    input  logic [MaskWidth-1:0] instr_mask,
    output logic                 instr_valid,
    output logic [DataWidth-1:0] instr_rdata,
    output logic                 instr_err,

    input  logic                 data_request,
    input  logic                 data_we_re,
    input  logic [DataWidth-1:0] data_address,
    input  logic [DataWidth-1:0] data_wdata,
    input  logic [MaskWidth-1:0] data_mask,
    output logic                 data_valid,
    output logic [DataWidth-1:0] data_rdata,
    output logic                 data_err,

    output logic                 mem_request,
    output logic                 mem_we_re,
    output logic [DataWidth-1:0] mem_address,
    output logic [DataWidth-1:0] mem_wdata,
    output logic [MaskWidth-1:0] mem_mask,
    input  logic                 mem_valid,
    input  logic [DataWidth-1:0] mem_rdata
);

    arb_state_e           r_state;
    arb_grant_e           r_grant;
    logic                 r_mem_request;
    logic                 r_mem_we_re;
    logic [DataWidth-1:0] r_mem_address;
    logic [DataWidth-1:0] r_mem_wdata;
    logic [MaskWidth-1:0] r_mem_mask;
    logic                 r_instr_valid;
    logic [DataWidth-1:0] r_instr_rdata;
    logic                 r_instr_err;
    logic                 r_data_valid;
    logic [DataWidth-1:0] r_data_rdata;
    logic                 r_data_err;

    arb_grant_e           w_grant;
    logic                 w_start;
    logic                 w_busy;
    logic                 w_expired;

    assign w_start = (r_state == IDLE) && (instr_request || data_request);
    assign w_busy  = (r_state == BUSY);

`ifdef ARB_ROUND_ROBIN_EN
    arb_grant_e r_last_grant;

    // Remember who was granted most recently so a conflict goes to the other side.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= GRANT_INSTR;
        end else if (w_start) begin
            r_last_grant <= w_grant;
        end
    end

    // A lone request wins outright. On a conflict, the side not served last wins.
    always_comb begin
        w_grant = data_request ? GRANT_DATA : GRANT_INSTR;
        if (instr_request && data_request) begin
            w_grant = (r_last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
        end
    end
`else
    // Fixed priority: any data request beats a fetch.
    always_comb begin
        w_grant = data_request ? GRANT_DATA : GRANT_INSTR;
    end
`endif

    mem_arb_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_start),
        .enable (w_busy),
        .expired(w_expired)
    );

    // Main FSM: capture the granted request, wait for completion, and issue one response pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_grant       <= GRANT_INSTR;
            r_mem_request <= 1'b0;
            r_mem_we_re   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_mask    <= '0;
            r_instr_valid <= 1'b0;
            r_instr_rdata <= '0;
            r_instr_err   <= 1'b0;
            r_data_valid  <= 1'b0;
            r_data_rdata  <= '0;
            r_data_err    <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            r_data_valid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_grant       <= w_grant;
                        r_mem_request <= 1'b1;
                        if (w_grant == GRANT_DATA) begin
                            r_mem_we_re   <= data_we_re;
                            r_mem_address <= data_address;
                            r_mem_wdata   <= data_wdata;
                            r_mem_mask    <= data_mask;
                        end else begin
                            r_mem_we_re   <= 1'b0;
                            r_mem_address <= instr_address;
                            r_mem_wdata   <= '0;
                            r_mem_mask    <= instr_mask;
                        end
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // A memory answer in the expiry cycle still counts as success.
                    if (mem_valid || w_expired) begin
                        r_mem_request <= 1'b0;
                        if (r_grant == GRANT_DATA) begin
                            r_data_valid <= 1'b1;
                            r_data_err   <= !mem_valid;
                            r_data_rdata <= (mem_valid && !r_mem_we_re) ? mem_rdata : '0;
                        end else begin
                            r_instr_valid <= 1'b1;
                            r_instr_err   <= !mem_valid;
                            r_instr_rdata <= mem_valid ? mem_rdata : '0;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_request = r_mem_request;
    assign mem_we_re   = r_mem_we_re;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign mem_mask    = r_mem_mask;
    assign instr_valid = r_instr_valid;
    assign instr_rdata = r_instr_rdata;
    assign instr_err   = r_instr_err;
    assign data_valid  = r_data_valid;
    assign data_rdata  = r_data_rdata;
    assign data_err    = r_data_err;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// A transaction-level model predicts the port outputs, and the outputs are compared every cycle.
// Directed scenarios add literal expectations on top of the model.
// Compile with ARB_ROUND_ROBIN_EN to exercise the round-robin build.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          instr_request = 1'b0;
    logic [DW-1:0] instr_address = '0;
    logic [3:0]    instr_mask = '0;
    logic          instr_valid;
    logic [DW-1:0] instr_rdata;
    logic          instr_err;
    logic          data_request = 1'b0;
    logic          data_we_re = 1'b0;
    logic [DW-1:0] data_address = '0;
    logic [DW-1:0] data_wdata = '0;
    logic [3:0]    data_mask = '0;
    logic          data_valid;
    logic [DW-1:0] data_rdata;
    logic          data_err;
    logic          mem_request;
    logic          mem_we_re;
    logic [DW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_mask;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DataWidth(DW), .TimeoutCycles(TO)) dut (
        .clk(clk), .rst(rst),
        .instr_request(instr_request), .instr_address(instr_address), .instr_mask(instr_mask),
        .instr_valid(instr_valid), .instr_rdata(instr_rdata), .instr_err(instr_err),
        .data_request(data_request), .data_we_re(data_we_re), .data_address(data_address),
        .data_wdata(data_wdata), .data_mask(data_mask),
        .data_valid(data_valid), .data_rdata(data_rdata), .data_err(data_err),
        .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: answers after mem_lat wait cycles (-1 = never). mem_force injects a stray pulse.
    int            mem_lat = 0;
    logic [DW-1:0] mem_rd_val = '0;
    logic          mem_force = 1'b0;
    int            mem_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (mem_request) mem_cnt++;
        else mem_cnt = 0;
        mem_valid = mem_force || (mem_request && (mem_lat >= 0) && (mem_cnt == mem_lat + 1));
        mem_rdata = mem_rd_val;
    end

    // Transaction model: an access granted at edge S completes at the first edge S+k (k>=1)
    // where mem_valid is seen, or at k == TO. The valid pulse follows, then the port is free again.
    int            cyc = 0;
    bit            m_ready = 0;
    bit            m_act = 0;
    bit            m_done = 0;
    int            m_start = 0;
    int            m_owner = 0;   // 0 = instruction, 1 = data
    int            m_last = 0;
    logic          e_mreq = 0, e_mwe = 0, e_ival = 0, e_dval = 0, e_err = 0, e_rst = 0;
    logic [DW-1:0] e_maddr = '0, e_mwdata = '0, e_rdata = '0;
    logic [3:0]    e_mmask = '0;

    always @(posedge clk) begin
        cyc++;
        e_ival = 0;
        e_dval = 0;
        e_rst  = 0;
        if (!rst) begin
            m_act = 0; m_done = 0; m_last = 0;
            e_mreq = 0; e_rst = 1; e_err = 0; e_rdata = '0;
        end else if (!m_act) begin
            if (instr_request || data_request) begin
                if (instr_request && data_request) begin
`ifdef ARB_ROUND_ROBIN_EN
                    m_owner = (m_last == 0) ? 1 : 0;
`else
                    m_owner = 1;
`endif
                end else begin
                    m_owner = data_request ? 1 : 0;
                end
                m_last = m_owner; m_act = 1; m_done = 0; m_start = cyc; e_mreq = 1;
                if (m_owner == 1) begin
                    e_mwe = data_we_re; e_maddr = data_address; e_mwdata = data_wdata; e_mmask = data_mask;
                end else begin
                    e_mwe = 0; e_maddr = instr_address; e_mwdata = '0; e_mmask = instr_mask;
                end
            end
        end else if (!m_done) begin
            if (mem_valid || (cyc - m_start >= TO)) begin
                m_done = 1; e_mreq = 0;
                e_err = !mem_valid;
                e_rdata = (mem_valid && !e_mwe) ? mem_rdata : '0;
                if (m_owner == 1) e_dval = 1;
                else e_ival = 1;
            end
        end else begin
            m_act = 0;
        end
        m_ready = 1;
    end

    // Compare and observe on the falling edge.
    int            q_served[$];
    logic          prev_mreq = 0;
    int            run_len = 0, last_run_len = 0;
    logic          obs_we = 0;
    logic [DW-1:0] obs_addr = '0, obs_wdata = '0;
    logic [3:0]    obs_mask = '0;
    logic [DW-1:0] last_i_rdata = '0, last_d_rdata = '0;
    logic          last_i_err = 0, last_d_err = 0;

    always @(negedge clk) begin
        if (m_ready) begin
            chk("mem_request", {31'b0, mem_request}, {31'b0, e_mreq});
            if (e_mreq) begin
                chk("mem_we_re", {31'b0, mem_we_re}, {31'b0, e_mwe});
                chk("mem_address", mem_address, e_maddr);
                chk("mem_wdata", mem_wdata, e_mwdata);
                chk("mem_mask", {28'b0, mem_mask}, {28'b0, e_mmask});
            end
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_ival});
            chk("data_valid", {31'b0, data_valid}, {31'b0, e_dval});
            if (e_ival) begin
                chk("instr_rdata", instr_rdata, e_rdata);
                chk("instr_err", {31'b0, instr_err}, {31'b0, e_err});
            end
            if (e_dval) begin
                chk("data_rdata", data_rdata, e_rdata);
                chk("data_err", {31'b0, data_err}, {31'b0, e_err});
            end
            if (e_rst) begin
                chk("rst_mem_we_re", {31'b0, mem_we_re}, 32'd0);
                chk("rst_mem_address", mem_address, 32'd0);
                chk("rst_mem_wdata", mem_wdata, 32'd0);
                chk("rst_mem_mask", {28'b0, mem_mask}, 32'd0);
                chk("rst_instr_rdata", instr_rdata, 32'd0);
                chk("rst_instr_err", {31'b0, instr_err}, 32'd0);
                chk("rst_data_rdata", data_rdata, 32'd0);
                chk("rst_data_err", {31'b0, data_err}, 32'd0);
            end
        end
        if (mem_request && !prev_mreq) begin
            obs_we = mem_we_re; obs_addr = mem_address; obs_wdata = mem_wdata; obs_mask = mem_mask;
        end
        if (mem_request) begin
            run_len++;
        end else if (prev_mreq) begin
            last_run_len = run_len;
            run_len = 0;
        end
        prev_mreq = mem_request;
        if (instr_valid) begin
            q_served.push_back(0);
            last_i_rdata = instr_rdata; last_i_err = instr_err;
            $display("txn instr rdata=%h err=%b t=%0t", instr_rdata, instr_err, $time);
        end
        if (data_valid) begin
            q_served.push_back(1);
            last_d_rdata = data_rdata; last_d_err = data_err;
            $display("txn data  rdata=%h err=%b t=%0t", data_rdata, data_err, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Raise the selected requests; each is dropped right after the edge that samples its valid.
    task automatic serve(input bit do_i, input bit do_d);
        bit pend_i, pend_d, drop_i, drop_d;
        pend_i = do_i; pend_d = do_d;
        instr_request = do_i; data_request = do_d;
        for (int k = 0; k < 200 && (pend_i || pend_d); k++) begin
            @(negedge clk); #1;
            drop_i = instr_valid; drop_d = data_valid;
            tick();
            if (drop_i) begin instr_request = 0; pend_i = 0; end
            if (drop_d) begin data_request = 0; pend_d = 0; end
        end
        if (pend_i || pend_d) begin
            total++; bad++;
            $display("FAIL serve_wait: got no valid within bound expected completion");
            instr_request = 0; data_request = 0;
        end
    endtask

    int exp_order[4];

    initial begin
        // Reset
        rst = 0;
        repeat (3) tick();
        rst = 1;
        tick();
        chk("reset_mem_request", {31'b0, mem_request}, 32'd0);

        // Single fetch, two wait cycles
        instr_address = 32'h0000_0040; instr_mask = 4'hF; mem_lat = 2; mem_rd_val = 32'hDEAD_BEEF;
        q_served.delete();
        serve(1, 0);
        chk("fetch_addr", obs_addr, 32'h40);
        chk("fetch_we", {31'b0, obs_we}, 32'd0);
        chk("fetch_rdata", last_i_rdata, 32'hDEAD_BEEF);
        chk("fetch_err", {31'b0, last_i_err}, 32'd0);
        chk("fetch_busy_len", last_run_len, 32'd3);
        chk("fetch_served_cnt", q_served.size(), 32'd1);

        // Isolated conflicts: data first every time in both builds
        data_we_re = 0; data_address = 32'h200; data_mask = 4'hF; instr_address = 32'h44; mem_lat = 1;
        mem_rd_val = 32'h0BAD_F00D;
        for (int r = 0; r < 4; r++) begin
            q_served.delete();
            serve(1, 1);
            chk("conflict_cnt", q_served.size(), 32'd2);
            if (q_served.size() == 2) begin
                chk("conflict_first", q_served[0], 32'd1);
                chk("conflict_second", q_served[1], 32'd0);
            end
        end

        // Continuous conflict: both requests held through four accesses
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        mem_lat = 0;
        q_served.delete();
        instr_request = 1; data_request = 1;
        for (int k = 0; k < 100 && q_served.size() < 4; k++) begin
            @(negedge clk); #1;
        end
        tick();
        instr_request = 0; data_request = 0;
        chk("cont_cnt", q_served.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < q_served.size()) chk("cont_order", q_served[k], exp_order[k]);
        end
        repeat (2) tick();

        // Store
        data_we_re = 1; data_address = 32'h100; data_wdata = 32'h1234_5678; data_mask = 4'b0011;
        mem_lat = 0; mem_rd_val = 32'hCAFE_F00D;
        serve(0, 1);
        chk("store_we", {31'b0, obs_we}, 32'd1);
        chk("store_addr", obs_addr, 32'h100);
        chk("store_wdata", obs_wdata, 32'h1234_5678);
        chk("store_mask", {28'b0, obs_mask}, 32'h3);
        chk("store_rdata", last_d_rdata, 32'd0);
        chk("store_busy_len", last_run_len, 32'd1);

        // Timeout: memory never answers
        data_we_re = 0; data_address = 32'h300; mem_lat = -1; mem_rd_val = 32'hBAD0_BAD0;
        serve(0, 1);
        chk("timeout_len", last_run_len, 32'd16);
        chk("timeout_err", {31'b0, last_d_err}, 32'd1);
        chk("timeout_rdata", last_d_rdata, 32'd0);

        // Answer in the expiry cycle is a success
        mem_lat = 15; mem_rd_val = 32'h5A5A_5A5A;
        serve(0, 1);
        chk("edge_len", last_run_len, 32'd16);
        chk("edge_err", {31'b0, last_d_err}, 32'd0);
        chk("edge_rdata", last_d_rdata, 32'h5A5A_5A5A);

        // Stray mem_valid while idle is ignored
        q_served.delete();
        mem_force = 1;
        tick();
        mem_force = 0;
        repeat (4) tick();
        chk("stray_valid_cnt", q_served.size(), 32'd0);

        // Reset in the middle of BUSY
        mem_lat = -1; instr_address = 32'h80; instr_request = 1;
        for (int k = 0; k < 20 && !mem_request; k++) begin
            @(negedge clk); #1;
        end
        tick();
        tick();
        rst = 0;
        tick();
        rst = 1; instr_request = 0;
        q_served.delete();
        chk("midrst_mem_request", {31'b0, mem_request}, 32'd0);
        repeat (3) tick();
        chk("midrst_no_valid", q_served.size(), 32'd0);
        mem_lat = 0; mem_rd_val = 32'h1111_2222; instr_address = 32'h84;
        serve(1, 0);
        chk("post_rst_rdata", last_i_rdata, 32'h1111_2222);
        chk("post_rst_addr", obs_addr, 32'h84);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got no finish expected finish before 100000ns");
        $fatal(1, "time limit");
    end

endmodule : tb_mem_port_arbiter
